// File: rtl/loproc_fetch_pkg.sv
// Shared widths and depths for the loproc instruction fetch unit.
package loproc_fetch_pkg;

    localparam int INSTRUCTION_WIDTH = 32;
    localparam int FETCH_DEPTH       = 2;

endpackage

// File: rtl/loproc_fetch_fifo.sv
// Synchronous FIFO with clear and occupancy count; used for the fetch address and data queues.
module loproc_fetch_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    input  logic                       clear,
    output logic [WIDTH-1:0]           head,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; count qualifies every read of head.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/loproc_fetch.sv
// Instruction fetch: issues in-order reads at the PC address, pairs returned words with
// their addresses and hands them to decode; drops responses made stale by a redirect.
module loproc_fetch
    import loproc_fetch_pkg::*;
#(
    parameter int INSTR_W = INSTRUCTION_WIDTH,
    parameter int DEPTH   = FETCH_DEPTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [INSTR_W-1:0] pc_addr,
    output logic               pc_load,
    input  logic               redirect,
    output logic               imem_req,
    output logic [INSTR_W-1:0] imem_addr,
    input  logic               imem_gnt,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               instr_valid,
    output logic [INSTR_W-1:0] instr_data,
    output logic [INSTR_W-1:0] instr_addr,
    input  logic               instr_ready
);

    localparam int CW = $clog2(DEPTH) + 1;
    // One spare bit: a second redirect can land before the first batch of stale data drains.
    localparam int DW = CW + 1;
    localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);

    logic [CW-1:0]      aq_count;
    logic [CW-1:0]      dq_count;
    logic [INSTR_W-1:0] aq_head;
    logic [INSTR_W-1:0] dq_head;
    logic [DW-1:0]      discard_cnt;

    logic issue;
    logic consume;
    logic drop_rsp;
    logic accept_rsp;

    // NOTE: every signal driven here gets a default first so no latch can be inferred.
    always_comb begin
        instr_valid = !rst && (dq_count != '0);
        consume     = instr_valid && instr_ready;
        // A pop in this cycle frees its credit immediately, sustaining one fetch per cycle.
        imem_req    = !rst && !redirect && ((aq_count < DEPTH_CNT) || consume);
        issue       = imem_req && imem_gnt;
        pc_load     = !rst && (redirect || issue);
        drop_rsp    = imem_rvalid && (discard_cnt != '0);
        accept_rsp  = imem_rvalid && (discard_cnt == '0) && !redirect && (aq_count > dq_count);
        imem_addr   = pc_addr;
        instr_data  = instr_valid ? dq_head : '0;
        instr_addr  = instr_valid ? aq_head : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            discard_cnt <= '0;
        end else if (redirect) begin
            discard_cnt <= discard_cnt - DW'(drop_rsp) + DW'(aq_count - dq_count);
        end else if (drop_rsp) begin
            discard_cnt <= discard_cnt - 1'b1;
        end
    end

    loproc_fetch_fifo #(
        .WIDTH (INSTR_W),
        .DEPTH (DEPTH)
    ) u_addr_q (
        .clk       (clk),
        .rst       (rst),
        .push      (issue),
        .push_data (pc_addr),
        .pop       (consume),
        .clear     (redirect),
        .head      (aq_head),
        .count     (aq_count)
    );

    loproc_fetch_fifo #(
        .WIDTH (INSTR_W),
        .DEPTH (DEPTH)
    ) u_data_q (
        .clk       (clk),
        .rst       (rst),
        .push      (accept_rsp),
        .push_data (imem_rdata),
        .pop       (consume),
        .clear     (redirect),
        .head      (dq_head),
        .count     (dq_count)
    );

    // Every response must belong to a stale or a live outstanding request.
    rsp_has_owner: assert property (@(posedge clk) disable iff (rst)
        imem_rvalid |-> ((discard_cnt != '0) || (aq_count > dq_count)));

endmodule

// File: tb/tb_loproc_fetch.sv
// Directed bench for loproc_fetch with a small PC model and an in-order memory model.
module tb_loproc_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_addr;
    logic        pc_load;
    logic        redirect;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr_data;
    logic [31:0] instr_addr;
    logic        instr_ready;

    logic [31:0] target;
    logic        mem_respond;
    logic [31:0] pend[$];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    loproc_fetch dut (
        .clk         (clk),
        .rst         (rst),
        .pc_addr     (pc_addr),
        .pc_load     (pc_load),
        .redirect    (redirect),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .instr_valid (instr_valid),
        .instr_data  (instr_data),
        .instr_addr  (instr_addr),
        .instr_ready (instr_ready)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic settle();
        #1;
    endtask

    // One clock: capture pre-edge handshakes, then update the PC and memory models.
    task automatic tick();
        logic        acc;
        logic        ld;
        logic        rd;
        logic        r;
        logic [31:0] a;
        acc = imem_req & imem_gnt;
        a   = imem_addr;
        ld  = pc_load;
        rd  = redirect;
        r   = rst;
        @(posedge clk);
        #1;
        if (r) begin
            pend.delete();
            pc_addr = 32'h0;
        end else begin
            if (acc) pend.push_back(a);
            if (ld) pc_addr = rd ? target : pc_addr + 32'd1;
        end
        if (!r && mem_respond && pend.size() > 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = 32'hA0 + pend.pop_front();
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = 32'h0;
        end
        #1;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        for (int i = 0; i < n; i++) tick();
        rst = 1'b0;
        settle();
    endtask

    initial begin
        rst = 1'b1; pc_addr = 32'h0; redirect = 1'b0; imem_gnt = 1'b1;
        imem_rvalid = 1'b0; imem_rdata = 32'h0; instr_ready = 1'b0;
        target = 32'h0; mem_respond = 1'b1;

        // 1: reset holds everything quiet, first cycle after issues address 0
        settle();
        for (int i = 0; i < 3; i++) begin
            check("rst_req", imem_req, 1'b0);
            check("rst_load", pc_load, 1'b0);
            check("rst_valid", instr_valid, 1'b0);
            tick();
        end
        rst = 1'b0;
        settle();
        check("post_rst_req", imem_req, 1'b1);
        check("post_rst_addr", imem_addr, 32'h0);
        check("post_rst_load", pc_load, 1'b1);

        // 2: streaming at one instruction per cycle
        instr_ready = 1'b1;
        settle();
        tick();
        check("stream_lat_valid", instr_valid, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stream_valid", instr_valid, 1'b1);
            check("stream_data", instr_data, 32'hA0 + 32'(i));
            check("stream_addr", instr_addr, 32'(i));
        end

        // 3: decode stalls, credit exhausts after two issues
        instr_ready = 1'b0;
        do_reset(1);
        check("stall_addr0", imem_addr, 32'h0);
        tick();
        check("stall_addr1", imem_addr, 32'h1);
        check("stall_req1", imem_req, 1'b1);
        tick();
        check("stall_full_req", imem_req, 1'b0);
        check("stall_full_load", pc_load, 1'b0);
        check("stall_full_valid", instr_valid, 1'b1);
        tick();
        check("stall_hold_req", imem_req, 1'b0);
        check("stall_hold_load", pc_load, 1'b0);
        tick();
        check("stall_hold_req2", imem_req, 1'b0);
        instr_ready = 1'b1;
        settle();
        check("release_addr", instr_addr, 32'h0);
        check("release_data", instr_data, 32'hA0);
        check("release_req", imem_req, 1'b1);
        check("release_issue_addr", imem_addr, 32'h2);
        check("release_load", pc_load, 1'b1);
        tick();
        check("release_next_addr", instr_addr, 32'h1);
        check("release_next_data", instr_data, 32'hA1);

        // 4: redirect with two requests outstanding
        mem_respond = 1'b0;
        do_reset(1);
        tick();
        tick();
        check("redir_pre_req", imem_req, 1'b0);
        check("redir_pre_valid", instr_valid, 1'b0);
        redirect = 1'b1;
        target = 32'h40;
        mem_respond = 1'b1;
        settle();
        check("redir_load", pc_load, 1'b1);
        check("redir_req", imem_req, 1'b0);
        tick();
        redirect = 1'b0;
        settle();
        check("redir_stale0_valid", instr_valid, 1'b0);
        check("redir_new_addr", imem_addr, 32'h40);
        tick();
        check("redir_stale1_valid", instr_valid, 1'b0);
        tick();
        check("redir_drained_valid", instr_valid, 1'b0);
        tick();
        check("redir_first_valid", instr_valid, 1'b1);
        check("redir_first_addr", instr_addr, 32'h40);
        check("redir_first_data", instr_data, 32'hE0);

        // 5: memory withholds grant
        imem_gnt = 1'b0;
        do_reset(1);
        for (int i = 0; i < 4; i++) begin
            check("nognt_req", imem_req, 1'b1);
            check("nognt_addr", imem_addr, 32'h0);
            check("nognt_load", pc_load, 1'b0);
            tick();
        end
        imem_gnt = 1'b1;
        settle();
        check("gnt_load", pc_load, 1'b1);

        // 6: reset with one word buffered and one request in flight
        instr_ready = 1'b0;
        mem_respond = 1'b1;
        do_reset(1);
        tick();
        mem_respond = 1'b0;
        tick();
        check("midrst_buffered", instr_valid, 1'b1);
        rst = 1'b1;
        mem_respond = 1'b1;
        settle();
        check("midrst_valid_in_rst", instr_valid, 1'b0);
        check("midrst_data_in_rst", instr_data, 32'h0);
        tick();
        rst = 1'b0;
        settle();
        check("midrst_valid_after", instr_valid, 1'b0);
        check("midrst_restart_addr", imem_addr, 32'h0);
        check("midrst_restart_load", pc_load, 1'b1);
        tick();
        check("midrst_lat_valid", instr_valid, 1'b0);
        tick();
        check("midrst_first_addr", instr_addr, 32'h0);
        check("midrst_first_data", instr_data, 32'hA0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
